// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1/8N2 UART transmitter, LSB first, registered tx.
// Optional parity bit between data and stop bits when UART_TX_PARITY_EN is defined.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       system_clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx
);

  localparam logic [15:0] CNT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] CNT_PRE   = 16'(CLKS_PER_BIT - 2);
  localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t      r_state, w_state_next;
  logic [15:0] r_cnt, w_cnt_next;
  logic [2:0]  r_idx, w_idx_next;
  logic [7:0]  r_shift, w_shift_next;
  logic        r_stop, w_stop_next;
  logic        r_tx, w_tx_next;
  logic        r_busy, w_busy_next;
  logic        r_done, w_done_next;
  logic        w_cnt_last;

`ifdef UART_TX_PARITY_EN
  logic r_par, w_par_next;

  always_ff @(posedge system_clk) begin
    if (reset) r_par <= 1'b0;
    else       r_par <= w_par_next;
  end
`else
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = (PARITY_ODD != 0);
`endif

  assign w_cnt_last = (r_cnt == CNT_LAST);

  always_ff @(posedge system_clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_stop  <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
      r_stop  <= w_stop_next;
      r_tx    <= w_tx_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_stop_next  = r_stop;
    w_tx_next    = r_tx;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_next   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        w_tx_next   = 1'b1;
        w_busy_next = 1'b0;
        if (tx_start) begin
          w_state_next = S_START;
          w_cnt_next   = '0;
          w_shift_next = tx_data;
          w_tx_next    = 1'b0;
          w_busy_next  = 1'b1;
`ifdef UART_TX_PARITY_EN
          w_par_next   = (^tx_data) ^ (PARITY_ODD != 0);
`endif
        end
      end
      S_START: begin
        if (w_cnt_last) begin
          w_cnt_next   = '0;
          w_state_next = S_DATA;
          w_idx_next   = '0;
          w_tx_next    = r_shift[0];
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      S_DATA: begin
        if (w_cnt_last) begin
          w_cnt_next   = '0;
          w_shift_next = r_shift >> 1;
          if (r_idx == 3'd7) begin
            w_stop_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
            w_state_next = S_PARITY;
            w_tx_next    = r_par;
`else
            w_state_next = S_STOP;
            w_tx_next    = 1'b1;
`endif
          end else begin
            w_idx_next = r_idx + 3'd1;
            w_tx_next  = r_shift[1];
          end
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_cnt_last) begin
          w_cnt_next   = '0;
          w_state_next = S_STOP;
          w_stop_next  = 1'b0;
          w_tx_next    = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
`endif
      S_STOP: begin
        w_tx_next = 1'b1;
        // The idle/done cycle is the last cycle of the final stop bit, so leave one early.
        if (r_stop == STOP_LAST && r_cnt == CNT_PRE) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
        end else if (w_cnt_last) begin
          w_cnt_next  = '0;
          w_stop_next = r_stop + 1'b1;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_tx_next    = 1'b1;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  assign tx      = r_tx;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - randomized self-checking bench for uart_transmitter.
// Two instances: 1 stop bit / even parity and 2 stop bits / odd parity.
module tb_uart_transmitter;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start [2];
  logic [7:0] tx_data  [2];
  logic       tx       [2];
  logic       tx_busy  [2];
  logic       tx_done  [2];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  uart_transmitter #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) u_dut0 (
    .system_clk(clk), .reset(rst), .tx_data(tx_data[0]), .tx_start(tx_start[0]),
    .tx_busy(tx_busy[0]), .tx_done(tx_done[0]), .tx(tx[0])
  );

  uart_transmitter #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1)) u_dut1 (
    .system_clk(clk), .reset(rst), .tx_data(tx_data[1]), .tx_start(tx_start[1]),
    .tx_busy(tx_busy[1]), .tx_done(tx_done[1]), .tx(tx[1])
  );

  function automatic int stop_bits(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int parity_odd(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int d, input string tag);
    check_val({tag, "_tx"},   32'(tx[d]),      32'd1);
    check_val({tag, "_busy"}, 32'(tx_busy[d]), 32'd0);
    check_val({tag, "_done"}, 32'(tx_done[d]), 32'd0);
  endtask

  // Present a request in the current (idle) cycle; the next edge accepts it.
  task automatic kick(input int d, input logic [7:0] data);
    check_val("pre_accept_busy", 32'(tx_busy[d]), 32'd0);
    tx_start[d] = 1'b1;
    tx_data[d]  = data;
  endtask

  // Called in the accept cycle; checks every line cycle of the frame against the
  // frame built from the byte, then decodes the byte from mid-bit samples.
  task automatic run_frame(input int d, input logic [7:0] data, input bit chain,
                           input logic [7:0] nxt, input int intrude_k, input int reset_k);
    bit         fb [12];
    int         nbits, total, ones, bit_no;
    logic [7:0] rx;
    ones  = 0;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fb[1 + i] = data[i];
      ones += int'(data[i]);
    end
    nbits = 9;
`ifdef UART_TX_PARITY_EN
    fb[nbits] = ((ones % 2) ^ parity_odd(d)) != 0;
    nbits++;
`endif
    for (int i = 0; i < stop_bits(d); i++) begin
      fb[nbits] = 1'b1;
      nbits++;
    end
    total = nbits * CPB;
    rx    = '0;
    tick();
    for (int k = 1; k <= total; k++) begin
      tx_start[d] = 1'b0;
      tx_data[d]  = 8'($urandom);
      bit_no      = (k - 1) / CPB;
      check_val("frame_tx",   32'(tx[d]),      32'(fb[bit_no]));
      check_val("frame_busy", 32'(tx_busy[d]), 32'(k < total));
      check_val("frame_done", 32'(tx_done[d]), 32'(k == total));
      if (((k - 1) % CPB) == CPB / 2 && bit_no >= 1 && bit_no <= 8)
        rx[bit_no - 1] = tx[d];
      if (k == intrude_k) begin
        tx_start[d] = 1'b1;
        tx_data[d]  = 8'hFF;
      end
      if (k == reset_k) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle(d, "after_reset");
        tick();
        check_idle(d, "after_reset_hold");
        return;
      end
      if (k == total && chain) begin
        tx_start[d] = 1'b1;
        tx_data[d]  = nxt;
      end
      if (k < total) tick();
    end
    check_val("decoded_byte", 32'(rx), 32'(data));
    if (!chain) begin
      tick();
      check_idle(d, "post_frame");
    end
  endtask

  initial begin
    logic [7:0] b, nb;
    bit         ch;
    int         intr;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      tx_start[d] = 1'b0;
      tx_data[d]  = 8'h00;
    end
    repeat (3) tick();
    rst = 1'b0;
    check_idle(0, "reset0");
    check_idle(1, "reset1");

    kick(0, 8'h55); run_frame(0, 8'h55, 1'b0, 8'h00, 0, 0);
    kick(0, 8'hA3); run_frame(0, 8'hA3, 1'b1, 8'h0F, 0, 0);
    run_frame(0, 8'h0F, 1'b0, 8'h00, 0, 0);
    kick(0, 8'h12); run_frame(0, 8'h12, 1'b0, 8'h00, 17, 0);
    kick(0, 8'h00); run_frame(0, 8'h00, 1'b0, 8'h00, 0, 4 * CPB + 2);
    kick(0, 8'h07); run_frame(0, 8'h07, 1'b0, 8'h00, 0, 0);

    kick(1, 8'h80); run_frame(1, 8'h80, 1'b0, 8'h00, 0, 0);
    kick(1, 8'h03); run_frame(1, 8'h03, 1'b0, 8'h00, 0, 0);
    kick(1, 8'h07); run_frame(1, 8'h07, 1'b1, 8'h5A, 0, 0);
    run_frame(1, 8'h5A, 1'b0, 8'h00, 0, 0);

    for (int d = 0; d < 2; d++) begin
      b = 8'($urandom);
      kick(d, b);
      for (int j = 0; j < 6; j++) begin
        nb   = 8'($urandom);
        ch   = (j < 5) && ($urandom_range(0, 1) == 1);
        intr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 9 * CPB)) : 0;
        run_frame(d, b, ch, nb, intr, 0);
        b = nb;
        if (!ch && j < 5) kick(d, b);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- 8N1/8N2 UART transmitter; the transmit-side counterpart to the team's UartReceiver.
- Serializes one byte per tx_start request onto tx, LSB first.
- Uses an internal bit-period counter clocked by system_clk, so no separate uart_clk is needed.
- Handshake is busy/done so host logic can stream bytes back-to-back without an idle gap.

Parameters:
- CLKS_PER_BIT, 868, system_clk cycles per bit; legal range 2..65535; counter width 16.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only when UART_TX_PARITY_EN is defined.

Ports:
- system_clk  input  1  single clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to send; sampled only on an accepted tx_start.
- tx_start  input  1  request; accepted in any cycle where tx_start=1 and tx_busy=0.
- tx_busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-cycle pulse at the end of a frame.
- tx  output  1  serial line, registered, idle high.

Behaviour:
- Reset (reset=1 at a clock edge): next cycle tx=1, tx_busy=0, tx_done=0, state=IDLE, bit counter=0, bit index=0, shift register=0. Reset applies mid-frame too: the frame is aborted and the line returns to idle immediately. No partial stop bit is emitted.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE:
  - tx=1.
  - On accept: latch tx_data into the shift register, clear the counter, go to START.
  - tx_busy=1 and tx=0 from the next cycle (one-cycle latency from accept to start-bit edge).
- Each bit state holds tx for exactly CLKS_PER_BIT cycles. The counter counts 0..CLKS_PER_BIT-1; at CLKS_PER_BIT-1 it wraps to 0 and the state or bit advances.
- START: tx=0 for one bit period, then go to DATA with bit index=0.
- DATA:
  - tx = shift register bit[0]; shift right at each bit-period end.
  - After bit index 7 completes, go to PARITY if the feature is enabled, else STOP.
- STOP:
  - tx=1 for STOP_BITS bit periods.
  - At the end of the last period: state=IDLE, tx_busy=0, tx_done=1 for exactly one cycle, all in the same cycle.
- Back-to-back: tx_start=1 in the tx_done cycle is accepted, because tx_busy is already 0. The next start bit begins the following cycle, so there is no idle gap beyond the stop bits.
- tx_start while tx_busy=1 is ignored; there is no queue. tx_data changes during a frame have no effect.
- Frame length: 1 + 8 + STOP_BITS bits, plus 1 if parity is enabled.
- Accept at cycle N -> tx_done at cycle N + frame_bits*CLKS_PER_BIT.
- tx is always driven from a flop; it has no combinational path from any input.

Optional Feature:
- UART_TX_PARITY_EN defined:
  - PARITY state is inserted between DATA and STOP and lasts one bit period.
  - tx = XOR of the 8 data bits when PARITY_ODD=0, and its inverse when PARITY_ODD=1.
  - Parity is computed from tx_data latched at accept.
- Undefined: no PARITY state or logic is built, and PARITY_ODD is ignored.

Test Plan:
- CLKS_PER_BIT=4, STOP_BITS=1, accept 0x55 at cycle 0 -> tx holds for 4 cycles each: 0,1,0,1,0,1,0,1,0,1. tx_busy=1 on cycles 1..39; tx_done=1 on cycle 40 only; tx=1 afterward.
- Back-to-back: send 0xA3 and hold tx_start=1 with 0x0F on the tx_done cycle -> the second start bit follows the first stop bit with no extra idle cycle. Decoded bytes are 0xA3 then 0x0F.
- Pulse tx_start with 0xFF while busy mid-frame (sending 0x12) -> ignored; only 0x12 is transmitted and tx_done pulses once.
- Assert reset for 1 cycle during data bit 3 of 0x00 -> tx=1 and tx_busy=0 next cycle, with no tx_done. A new tx_start is then accepted normally.
- STOP_BITS=2, CLKS_PER_BIT=4, send 0x80 -> tx high for 8 cycles after bit 7; tx_done at cycle 44.
- UART_TX_PARITY_EN, PARITY_ODD=0, send 0x07 -> parity bit=1. With PARITY_ODD=1 and 0x03, parity bit=1; with 0x07, parity bit=0.
